nco_phase_gen: RTL and testbench



---
 rtl/nco_phase_gen_if.sv | 25 ++
 rtl/nco_phase_gen.sv | 85 ++++++++
 tb/tb_nco_phase_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/nco_phase_gen_if.sv
// Control and angle bundle between the NCO and its driver.
// The driver owns the tuning/offset/dither controls; the NCO returns ack, angle and valid.
interface nco_phase_gen_if #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 20
);
    logic [ACC_WIDTH-1:0] freq_in;
    logic                 freq_load;
    logic                 freq_ack;
    logic                 phase_clr;
    logic                 dither_en;
    logic [OUT_WIDTH-1:0] phase_off;
    logic [OUT_WIDTH-1:0] ain;
    logic                 phase_valid;

    modport master (
        output freq_in, freq_load, phase_clr, dither_en, phase_off,
        input  freq_ack, ain, phase_valid
    );

    modport slave (
        input  freq_in, freq_load, phase_clr, dither_en, phase_off,
        output freq_ack, ain, phase_valid
    );
endinterface

// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO producing the CORDIC rotation angle, with optional
// LFSR dither below the truncation point and a static phase offset.
module nco_phase_gen #(
    parameter int          ACC_WIDTH = 32,
    parameter int          OUT_WIDTH = 20,
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic              clk,
    input  logic              reset,
    nco_phase_gen_if.slave    bus
);
    localparam int DITHER_WIDTH = ACC_WIDTH - OUT_WIDTH;

    logic [ACC_WIDTH-1:0]    acc_reg;
    logic [ACC_WIDTH-1:0]    freq_reg;
    logic [ACC_WIDTH-1:0]    pend_reg;
    logic                    pend_flag_reg;
    logic [14:0]             lfsr_reg;
    logic [14:0]             lfsr_next;
    logic [OUT_WIDTH-1:0]    ain_reg;
    logic [OUT_WIDTH-1:0]    ain_next;
    logic                    freq_ack_reg;
    logic [1:0]              valid_pipe_reg;
    logic [DITHER_WIDTH-1:0] dither_bits;
    logic                    dither_carry;

    genvar gi;

    // Fibonacci LFSR, x^15 + x^14 + 1, shifting left.
    assign lfsr_next[0] = lfsr_reg[14] ^ lfsr_reg[13];
    generate
        for (gi = 1; gi < 15; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    assign dither_bits = bus.dither_en ? lfsr_reg[DITHER_WIDTH-1:0] : '0;

    // Only the carry out of the dithered fraction reaches the output:
    // low + d overflows exactly when low > ~d.
    assign dither_carry = (acc_reg[DITHER_WIDTH-1:0] > ~dither_bits);

    assign ain_next = acc_reg[ACC_WIDTH-1 -: OUT_WIDTH]
                    + {{(OUT_WIDTH-1){1'b0}}, dither_carry}
                    + bus.phase_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg        <= '0;
            freq_reg       <= '0;
            pend_reg       <= '0;
            pend_flag_reg  <= 1'b0;
            lfsr_reg       <= LFSR_SEED;
            ain_reg        <= '0;
            freq_ack_reg   <= 1'b0;
            valid_pipe_reg <= 2'b00;
        end else begin
            lfsr_reg <= lfsr_next;

            if (bus.phase_clr) begin
                acc_reg <= '0;
            end else begin
                acc_reg <= acc_reg + freq_reg;
            end

            // Every strobe overwrites the pending word; a pending word always
            // transfers on the following edge, so the last strobe wins.
            if (bus.freq_load) begin
                pend_reg <= bus.freq_in;
            end
            pend_flag_reg <= bus.freq_load;
            if (pend_flag_reg) begin
                freq_reg <= pend_reg;
            end
            freq_ack_reg <= pend_flag_reg;

            ain_reg        <= ain_next;
            valid_pipe_reg <= {valid_pipe_reg[0], 1'b1};
        end
    end

    assign bus.ain         = ain_reg;
    assign bus.freq_ack    = freq_ack_reg;
    assign bus.phase_valid = valid_pipe_reg[1];
endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed self-checking bench for nco_phase_gen: load handshake, wrap,
// phase clear, offset steps, reset with a pending load and dither statistics.
module tb_nco_phase_gen;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [19:0] exp_ain;

    nco_phase_gen_if bus ();

    nco_phase_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("  ok %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect ain to move by a fixed step on each of n edges.
    task automatic step_n(input int n, input logic [19:0] step);
        for (int i = 0; i < n; i++) begin
            tick();
            exp_ain = exp_ain + step;
            chk("step", {12'h0, bus.ain}, {12'h0, exp_ain});
        end
    endtask

    initial begin
        logic [31:0] acc_m;
        logic [19:0] undith;
        logic [19:0] diff;
        logic [19:0] first_ain;
        logic [19:0] span;
        int          n_bad;
        int          n_one;

        n_cmp = 0;
        n_err = 0;
        exp_ain = '0;
        reset = 1'b1;
        bus.freq_in   = '0;
        bus.freq_load = 1'b0;
        bus.phase_clr = 1'b0;
        bus.dither_en = 1'b0;
        bus.phase_off = '0;
        tick(); tick(); tick();
        chk("rst_ain",   {12'h0, bus.ain}, 32'h0);
        chk("rst_ack",   {31'h0, bus.freq_ack}, 32'h0);
        chk("rst_valid", {31'h0, bus.phase_valid}, 32'h0);

        reset = 1'b0;
        tick();
        chk("valid_e1", {31'h0, bus.phase_valid}, 32'h0);
        tick();
        chk("valid_e2", {31'h0, bus.phase_valid}, 32'h1);

        // Test 1: load 0x1000, count up by one LSB per clock
        bus.freq_in = 32'h0000_1000; bus.freq_load = 1'b1;
        tick();
        bus.freq_load = 1'b0;
        chk("t1_ack_k", {31'h0, bus.freq_ack}, 32'h0);
        tick();
        chk("t1_ack_k1", {31'h0, bus.freq_ack}, 32'h1);
        tick();
        chk("t1_ack_k2", {31'h0, bus.freq_ack}, 32'h0);
        chk("t1_ain_k2", {12'h0, bus.ain}, 32'h0);
        exp_ain = 20'h0;
        step_n(8, 20'h1);

        // Test 2: half-rate word with a phase clear, then negative word
        bus.freq_in = 32'h8000_0000; bus.freq_load = 1'b1;
        tick();
        chk("t2_ain_k", {12'h0, bus.ain}, 32'h9);
        bus.freq_load = 1'b0; bus.phase_clr = 1'b1;
        tick();
        chk("t2_ack_k1", {31'h0, bus.freq_ack}, 32'h1);
        chk("t2_ain_k1", {12'h0, bus.ain}, 32'hA);
        bus.phase_clr = 1'b0;
        tick();
        chk("t2_ain_k2", {12'h0, bus.ain}, 32'h0);
        exp_ain = 20'h0;
        step_n(5, 20'h80000);

        bus.freq_in = 32'hFFFF_F000; bus.freq_load = 1'b1;
        tick();
        chk("t2n_ain_k", {12'h0, bus.ain}, 32'h0);
        bus.freq_load = 1'b0;
        tick();
        chk("t2n_ack_k1", {31'h0, bus.freq_ack}, 32'h1);
        chk("t2n_ain_k1", {12'h0, bus.ain}, 32'h80000);
        tick();
        chk("t2n_ain_k2", {12'h0, bus.ain}, 32'h0);
        exp_ain = 20'h0;
        step_n(6, 20'hFFFFF);

        // Back to +1 per clock, crossing FFFFF -> 00000
        bus.freq_in = 32'h0000_1000; bus.freq_load = 1'b1;
        tick();
        chk("t1w_ain_k", {12'h0, bus.ain}, 32'hFFFF9);
        bus.freq_load = 1'b0;
        tick();
        chk("t1w_ack_k1", {31'h0, bus.freq_ack}, 32'h1);
        chk("t1w_ain_k1", {12'h0, bus.ain}, 32'hFFFF8);
        tick();
        chk("t1w_ain_k2", {12'h0, bus.ain}, 32'hFFFF7);
        exp_ain = 20'hFFFF7;
        step_n(11, 20'h1);

        // Test 3: phase clear together with a new offset
        bus.phase_clr = 1'b1; bus.phase_off = 20'h12345;
        tick();
        chk("t3_ain_c", {12'h0, bus.ain}, 32'h12348);
        bus.phase_clr = 1'b0;
        tick();
        chk("t3_ain_off", {12'h0, bus.ain}, 32'h12345);
        chk("t3_ack", {31'h0, bus.freq_ack}, 32'h0);
        exp_ain = 20'h12345;
        step_n(4, 20'h1);
        chk("t3_ack_end", {31'h0, bus.freq_ack}, 32'h0);

        // Test 6: offset step of 2^19 coinciding with a reload
        bus.phase_off = 20'h92345; bus.freq_in = 32'h0000_1000; bus.freq_load = 1'b1;
        tick();
        chk("t6_ain_jump", {12'h0, bus.ain}, 32'h9234A);
        chk("t6_ack_k", {31'h0, bus.freq_ack}, 32'h0);
        bus.freq_load = 1'b0;
        tick();
        chk("t6_ain_k1", {12'h0, bus.ain}, 32'h9234B);
        chk("t6_ack_k1", {31'h0, bus.freq_ack}, 32'h1);
        tick();
        chk("t6_ain_k2", {12'h0, bus.ain}, 32'h9234C);
        chk("t6_ack_k2", {31'h0, bus.freq_ack}, 32'h0);

        // Test 4: three consecutive loads, last word wins
        bus.phase_off = 20'h0; bus.phase_clr = 1'b1;
        tick();
        chk("t4_ain_p", {12'h0, bus.ain}, 32'h8);
        bus.phase_clr = 1'b0;
        bus.freq_in = 32'h0000_1000; bus.freq_load = 1'b1;
        tick();
        chk("t4_ack_k1", {31'h0, bus.freq_ack}, 32'h0);
        chk("t4_ain_k1", {12'h0, bus.ain}, 32'h0);
        bus.freq_in = 32'h0000_2000;
        tick();
        chk("t4_ack_k2", {31'h0, bus.freq_ack}, 32'h1);
        chk("t4_ain_k2", {12'h0, bus.ain}, 32'h1);
        bus.freq_in = 32'h0000_3000;
        tick();
        chk("t4_ack_k3", {31'h0, bus.freq_ack}, 32'h1);
        chk("t4_ain_k3", {12'h0, bus.ain}, 32'h2);
        bus.freq_load = 1'b0;
        tick();
        chk("t4_ack_k4", {31'h0, bus.freq_ack}, 32'h1);
        chk("t4_ain_k4", {12'h0, bus.ain}, 32'h3);
        tick();
        chk("t4_ack_k5", {31'h0, bus.freq_ack}, 32'h0);
        chk("t4_ain_k5", {12'h0, bus.ain}, 32'h5);
        tick();
        chk("t4_ain_k6", {12'h0, bus.ain}, 32'h8);
        tick();
        chk("t4_ain_k7", {12'h0, bus.ain}, 32'hB);

        // Reset while a load is pending
        bus.freq_in = 32'h0000_5000; bus.freq_load = 1'b1;
        tick();
        chk("t4_ain_pend", {12'h0, bus.ain}, 32'hE);
        bus.freq_load = 1'b0; reset = 1'b1;
        tick();
        chk("t4r_ack", {31'h0, bus.freq_ack}, 32'h0);
        chk("t4r_ain", {12'h0, bus.ain}, 32'h0);
        chk("t4r_valid", {31'h0, bus.phase_valid}, 32'h0);
        reset = 1'b0;
        tick();
        chk("t4r_ack_e1", {31'h0, bus.freq_ack}, 32'h0);
        chk("t4r_valid_e1", {31'h0, bus.phase_valid}, 32'h0);
        tick();
        chk("t4r_valid_e2", {31'h0, bus.phase_valid}, 32'h1);
        tick();
        chk("t4r_freq_zero", {12'h0, bus.ain}, 32'h0);

        // Test 5: dither with acc=0 never carries
        bus.phase_off = 20'h40000; bus.dither_en = 1'b1;
        tick();
        chk("t5_d_on0", {12'h0, bus.ain}, 32'h40000);
        tick();
        chk("t5_d_on1", {12'h0, bus.ain}, 32'h40000);
        bus.dither_en = 1'b0;
        tick();
        chk("t5_d_off", {12'h0, bus.ain}, 32'h40000);
        bus.dither_en = 1'b1;
        tick();
        chk("t5_d_on2", {12'h0, bus.ain}, 32'h40000);

        // Dithered half-LSB step: error is 0 or +1, mean increment near 0.5
        bus.freq_in = 32'h0000_0800; bus.freq_load = 1'b1;
        tick();
        bus.freq_load = 1'b0; bus.phase_clr = 1'b1;
        tick();
        bus.phase_clr = 1'b0;
        n_bad = 0;
        n_one = 0;
        first_ain = '0;
        for (int m = 0; m < 4096; m++) begin
            tick();
            acc_m  = 32'(m) * 32'h0000_0800;
            undith = acc_m[31:12] + 20'h40000;
            diff   = bus.ain - undith;
            if (diff > 20'd1) n_bad++;
            if (diff == 20'd1) n_one++;
            if (m == 0) first_ain = bus.ain;
        end
        span = bus.ain - first_ain;
        chk("t5_dith_range", 32'(n_bad), 32'h0);
        chk("t5_dith_active", {31'h0, (n_one >= 700 && n_one <= 1400)}, 32'h1);
        chk("t5_mean_incr", {31'h0, (span >= 20'd1966 && span <= 20'd2130)}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
